// File: rtl/bus_decoder.sv
// Registered base/mask address decoder and single-outstanding request router.
// Define BUS_TIMEOUT_EN to build the hung-slave timeout (abort after TIMEOUT cycles in REQ/RESP).
module bus_decoder #(
   parameter int XLEN = 32,
   parameter int NUM_SLV = 4,
   // Slave 0 occupies the least-significant XLEN bits of each flattened vector.
   parameter logic [NUM_SLV*XLEN-1:0] SLV_BASE = {32'h2000_0000, 32'h1000_1000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLV*XLEN-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_C000},
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    m_req,
   input  logic                    m_we,
   input  logic [XLEN-1:0]         m_addr,
   input  logic [XLEN-1:0]         m_wdata,
   input  logic [3:0]              m_wstrb,
   output logic                    m_gnt,
   output logic                    m_rvalid,
   output logic [XLEN-1:0]         m_rdata,
   output logic                    m_err,
   output logic [NUM_SLV-1:0]      s_req,
   output logic                    s_we,
   output logic [XLEN-1:0]         s_wdata,
   output logic [3:0]              s_wstrb,
   output logic [XLEN-1:0]         s_addr,
   input  logic [NUM_SLV-1:0]      s_gnt,
   input  logic [NUM_SLV-1:0]      s_rvalid,
   input  logic [NUM_SLV*XLEN-1:0] s_rdata
);

   localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

   state_t            state_reg, state_next;
   logic [SEL_W-1:0]  sel_reg;
   logic [XLEN-1:0]   s_addr_reg, s_wdata_reg, m_rdata_reg;
   logic [3:0]        s_wstrb_reg;
   logic              s_we_reg, m_rvalid_reg, m_err_reg;

   logic [NUM_SLV-1:0] match;
   logic [XLEN-1:0]    base_arr  [NUM_SLV];
   logic [XLEN-1:0]    rdata_arr [NUM_SLV];
   logic               hit;
   logic [SEL_W-1:0]   hit_sel;
   logic [XLEN-1:0]    offset;
   logic               can_accept, accept;
   logic               resp_ok, resp_err;
   logic               tmo_hit;

   if (NUM_SLV < 1 || NUM_SLV > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
      $error("bus_decoder: NUM_SLV or TIMEOUT out of range");
   end

   generate
      for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
         assign base_arr[gi]  = SLV_BASE[gi*XLEN +: XLEN];
         assign rdata_arr[gi] = s_rdata[gi*XLEN +: XLEN];
         assign match[gi]     = (m_addr & SLV_MASK[gi*XLEN +: XLEN]) ==
                                (SLV_BASE[gi*XLEN +: XLEN] & SLV_MASK[gi*XLEN +: XLEN]);
      end
   endgenerate

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_sel = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit     = 1'b1;
            hit_sel = SEL_W'(i);
         end
      end
   end

   assign offset = m_addr - base_arr[hit_sel];

   // The response pulse cycle is already back in IDLE, so it must still refuse new work.
   assign can_accept = (state_reg == IDLE) && !m_rvalid_reg;
   assign accept     = can_accept && m_req;
   assign m_gnt      = can_accept && !rst;

`ifdef BUS_TIMEOUT_EN
   logic [15:0] tmo_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_reg <= '0;
      end else if (accept) begin
         tmo_cnt_reg <= '0;
      end else if (state_reg == REQ || state_reg == RESP) begin
         tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
      end
   end

   // >= keeps the abort armed if a grant lands on the limit cycle and RESP follows.
   assign tmo_hit = (tmo_cnt_reg >= 16'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      resp_ok    = 1'b0;
      resp_err   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (hit) begin
                  state_next = REQ;
               end else begin
                  state_next = ERR;
                  resp_err   = 1'b1;
               end
            end
         end
         REQ: begin
            if (s_gnt[sel_reg]) begin
               state_next = RESP;
            end else if (tmo_hit) begin
               state_next = ERR;
               resp_err   = 1'b1;
            end
         end
         RESP: begin
            if (s_rvalid[sel_reg]) begin
               state_next = IDLE;
               resp_ok    = 1'b1;
            end else if (tmo_hit) begin
               state_next = ERR;
               resp_err   = 1'b1;
            end
         end
         ERR: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_reg      <= '0;
         s_addr_reg   <= '0;
         s_we_reg     <= 1'b0;
         s_wdata_reg  <= '0;
         s_wstrb_reg  <= '0;
         m_rvalid_reg <= 1'b0;
         m_err_reg    <= 1'b0;
         m_rdata_reg  <= '0;
      end else begin
         m_rvalid_reg <= resp_ok || resp_err;
         if (resp_ok) begin
            m_err_reg   <= 1'b0;
            m_rdata_reg <= rdata_arr[sel_reg];
         end else if (resp_err) begin
            m_err_reg   <= 1'b1;
            m_rdata_reg <= '0;
         end
         if (accept) begin
            sel_reg     <= hit_sel;
            s_addr_reg  <= offset;
            s_we_reg    <= m_we;
            s_wdata_reg <= m_wdata;
            s_wstrb_reg <= m_wstrb;
         end
      end
   end

   always_comb begin
      s_req = '0;
      if (state_reg == REQ) begin
         s_req[sel_reg] = 1'b1;
      end
   end

   assign s_addr   = s_addr_reg;
   assign s_we     = s_we_reg;
   assign s_wdata  = s_wdata_reg;
   assign s_wstrb  = s_wstrb_reg;
   assign m_rvalid = m_rvalid_reg;
   assign m_err    = m_err_reg;
   assign m_rdata  = m_rdata_reg;

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: vector table, hand-written corner sequences, random traffic.
// Timeout expectations switch on BUS_TIMEOUT_EN, matching how the design was built.
module tb_bus_decoder;

   localparam int XLEN = 32;
   localparam int NSLV = 4;
   // Slave 2 is widened to overlap slave 1 and its base sits above part of its window.
   localparam logic [NSLV*XLEN-1:0] TB_BASE = {32'h2000_0000, 32'h1000_4000, 32'h1000_0000, 32'h0000_0000};
   localparam logic [NSLV*XLEN-1:0] TB_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_C000};
   localparam int TB_TIMEOUT = 8;
`ifdef BUS_TIMEOUT_EN
   localparam int MAX_DLY = 2;
`else
   localparam int MAX_DLY = 4;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              m_req = 1'b0;
   logic              m_we = 1'b0;
   logic [31:0]       m_addr = '0;
   logic [31:0]       m_wdata = '0;
   logic [3:0]        m_wstrb = '0;
   logic              m_gnt, m_rvalid, m_err;
   logic [31:0]       m_rdata;
   logic [NSLV-1:0]   s_req;
   logic              s_we;
   logic [31:0]       s_wdata, s_addr;
   logic [3:0]        s_wstrb;
   logic [NSLV-1:0]   s_gnt = '0;
   logic [NSLV-1:0]   s_rvalid = '0;
   logic [NSLV*32-1:0] s_rdata = '0;

   bus_decoder #(
      .XLEN(XLEN), .NUM_SLV(NSLV), .SLV_BASE(TB_BASE), .SLV_MASK(TB_MASK), .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
      .s_req(s_req), .s_we(s_we), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_addr(s_addr),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Memory map as the software sees it: slave index -> base, mask.
   logic [31:0] map_base [NSLV] = '{32'h0000_0000, 32'h1000_0000, 32'h1000_4000, 32'h2000_0000};
   logic [31:0] map_mask [NSLV] = '{32'hFFFF_C000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          gdly;
      int          rdly;
      logic [31:0] sdata;
      int          sel;
      logic [31:0] off;
      int          lat;
      bit          err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void decode(input logic [31:0] a, output int sel, output logic [31:0] off);
      sel = -1;
      off = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (sel < 0 && (a & map_mask[i]) == (map_base[i] & map_mask[i])) begin
            sel = i;
            off = a - map_base[i];
         end
      end
   endfunction

   task automatic check_reset_vals();
      check("rst_m_gnt", m_gnt, 0);
      check("rst_m_rvalid", m_rvalid, 0);
      check("rst_m_err", m_err, 0);
      check("rst_m_rdata", m_rdata, 0);
      check("rst_s_req", s_req, 0);
      check("rst_s_addr", s_addr, 0);
      check("rst_s_we", s_we, 0);
      check("rst_s_wdata", s_wdata, 0);
      check("rst_s_wstrb", s_wstrb, 0);
   endtask

   // Slave behaviour for cycle n after accept: grant at 1+gdly, response rdly cycles later.
   // Stray strobes from other slaves, and ignorable ones from the selected slave, are mixed in.
   task automatic drive_slaves(input int n, input int sel, input int gdly, input int rdly,
                               input logic [31:0] sdata);
      logic [NSLV-1:0]    g, v;
      logic [NSLV*32-1:0] d;
      for (int i = 0; i < NSLV; i++) begin
         g[i] = 1'($urandom_range(0, 1));
         v[i] = 1'($urandom_range(0, 1));
         d[i*32 +: 32] = $urandom;
      end
      if (sel >= 0) begin
         g[sel] = (n == 1 + gdly) || (n > 1 + gdly && $urandom_range(0, 3) == 0);
         v[sel] = (n == 2 + gdly + rdly) || (n <= 1 + gdly && $urandom_range(0, 3) == 0);
         if (n == 2 + gdly + rdly) d[sel*32 +: 32] = sdata;
      end
      s_gnt    = g;
      s_rvalid = v;
      s_rdata  = d;
   endtask

   task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int gdly, input int rdly,
                          input logic [31:0] sdata, input int sel, input logic [31:0] off,
                          input int budget, output int lat, output logic err,
                          output logic [31:0] rdata, output int sreq_cnt, output int sreq_bad,
                          output int fld_bad, output int gnt_bad);
      logic [NSLV-1:0] exp_req;
      lat = -1; err = 1'b0; rdata = '0;
      sreq_cnt = 0; sreq_bad = 0; fld_bad = 0; gnt_bad = 0;
      @(negedge clk);
      check("rvalid_one_cycle", m_rvalid, 0);
      check("gnt_idle", m_gnt, 1);
      m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
      drive_slaves(0, -1, 0, 0, '0);
      @(negedge clk);
      // Scramble the master bus so only the registered copies can satisfy the field checks.
      m_req = 1'b0; m_we = 1'($urandom_range(0, 1)); m_addr = $urandom; m_wdata = $urandom;
      m_wstrb = 4'($urandom);
      for (int n = 1; n <= budget; n++) begin
         if (m_gnt) gnt_bad++;
         if (m_rvalid) begin
            lat = n; err = m_err; rdata = m_rdata;
            break;
         end
         exp_req = (sel >= 0 && n <= 1 + gdly) ? NSLV'(1 << sel) : '0;
         if (s_req !== exp_req) sreq_bad++;
         if (s_req != '0) sreq_cnt++;
         if (sel >= 0 && (s_addr !== off || s_we !== we || s_wdata !== wdata || s_wstrb !== wstrb))
            fld_bad++;
         drive_slaves(n, sel, gdly, rdly, sdata);
         @(negedge clk);
      end
      s_gnt = '0;
      s_rvalid = '0;
      $display("txn we=%0b addr=%h sel=%0d gdly=%0d rdly=%0d -> lat=%0d err=%0b rdata=%h",
               we, addr, sel, gdly, rdly, lat, err, rdata);
   endtask

   task automatic run_and_check(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int gdly, input int rdly,
                                input logic [31:0] sdata, input int sel, input logic [31:0] off,
                                input int exp_lat, input bit exp_err, input logic [31:0] exp_rdata);
      int lat, sreq_cnt, sreq_bad, fld_bad, gnt_bad;
      logic err;
      logic [31:0] rdata;
      run_txn(we, addr, wdata, wstrb, gdly, rdly, sdata, sel, off, 40,
              lat, err, rdata, sreq_cnt, sreq_bad, fld_bad, gnt_bad);
      check("latency", lat, exp_lat);
      check("m_err", err, exp_err);
      check("m_rdata", rdata, exp_rdata);
      check("s_req_cycles", sreq_cnt, (sel < 0) ? 0 : gdly + 1);
      check("s_req_onehot_bad_cycles", sreq_bad, 0);
      check("s_fields_bad_cycles", fld_bad, 0);
      check("m_gnt_high_while_busy", gnt_bad, 0);
   endtask

   task automatic idle_quiet(input int cycles, input logic [NSLV-1:0] stray);
      for (int i = 0; i < cycles; i++) begin
         s_gnt = stray;
         s_rvalid = stray;
         s_rdata = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check("idle_no_rvalid", m_rvalid, 0);
         check("idle_gnt", m_gnt, 1);
      end
      s_gnt = '0;
      s_rvalid = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, sreq_cnt, sreq_bad, fld_bad, gnt_bad;
      logic err;
      logic [31:0] rdata;

      //          we    addr          wdata         strb    g  r  sdata         sel off           lat err rdata
      vecs[0] = '{1'b0, 32'h1000_0004, 32'h0,        4'hF,   0, 0, 32'hA5A5_0001, 1, 32'h4,        3, 1'b0, 32'hA5A5_0001};
      vecs[1] = '{1'b1, 32'h2000_0010, 32'h1234_5678, 4'b0011, 5, 0, 32'hCAFE_0003, 3, 32'h10,      8, 1'b0, 32'hCAFE_0003};
      vecs[2] = '{1'b0, 32'h3000_0000, 32'h0,        4'hF,   0, 0, 32'h1111_1111, -1, 32'h0,       1, 1'b1, 32'h0};
      vecs[3] = '{1'b0, 32'h1000_0800, 32'h0,        4'hF,   1, 2, 32'h2222_0002, 1, 32'h800,      6, 1'b0, 32'h2222_0002};
      vecs[4] = '{1'b0, 32'h1000_2000, 32'h0,        4'hF,   0, 1, 32'h0BAD_F00D, 2, 32'hFFFF_E000, 4, 1'b0, 32'h0BAD_F00D};
      vecs[5] = '{1'b1, 32'h0000_3FFC, 32'h8765_4321, 4'hF,   2, 3, 32'h0,         0, 32'h3FFC,     8, 1'b0, 32'h0};
      vecs[6] = '{1'b0, 32'h0000_4000, 32'h0,        4'hF,   0, 0, 32'h7777_7777, -1, 32'h0,       1, 1'b1, 32'h0};
      vecs[7] = '{1'b0, 32'h2000_FFFF, 32'h0,        4'hF,   0, 0, 32'h3333_3333, 3, 32'hFFFF,     3, 1'b0, 32'h3333_3333};
      vecs[8] = '{1'b1, 32'h1000_4FF0, 32'h5555_AAAA, 4'hC,   1, 0, 32'h4444_4444, 2, 32'h0FF0,     4, 1'b0, 32'h4444_4444};

      repeat (2) @(negedge clk);
      check_reset_vals();
      rst = 1'b0;

      foreach (vecs[k]) begin
         run_and_check(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb, vecs[k].gdly,
                       vecs[k].rdly, vecs[k].sdata, vecs[k].sel, vecs[k].off,
                       vecs[k].lat, vecs[k].err, vecs[k].rdata);
         idle_quiet(1, '0);
      end

      // Slave 0 never grants.
`ifdef BUS_TIMEOUT_EN
      run_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 1000, 0, 32'h0, 0, 32'h100, 40,
              lat, err, rdata, sreq_cnt, sreq_bad, fld_bad, gnt_bad);
      check("timeout_latency", lat, TB_TIMEOUT + 1);
      check("timeout_err", err, 1);
      check("timeout_rdata", rdata, 0);
      check("timeout_s_req_cycles", sreq_cnt, TB_TIMEOUT);
      check("timeout_s_req_bad_cycles", sreq_bad, 0);
      check("timeout_gnt_high_while_busy", gnt_bad, 0);
      idle_quiet(3, 4'b0001);
`else
      run_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 1000, 0, 32'h0, 0, 32'h100, 40,
              lat, err, rdata, sreq_cnt, sreq_bad, fld_bad, gnt_bad);
      check("hang_no_response", lat, -1);
      check("hang_s_req_cycles", sreq_cnt, 40);
      check("hang_s_req_bad_cycles", sreq_bad, 0);
      check("hang_gnt_high_while_busy", gnt_bad, 0);
      rst = 1'b1;
      #1;
      check_reset_vals();
      @(negedge clk);
      rst = 1'b0;
      idle_quiet(3, 4'b0001);
`endif

      // Reset while the read to slave 1 sits in RESP; the late response must vanish.
      @(negedge clk);
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0008;
      @(negedge clk);
      m_req = 1'b0; s_gnt = 4'b0010;
      @(negedge clk);
      s_gnt = '0;
      check("resp_s_req_low", s_req, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_vals();
      @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      s_rvalid = 4'b0010;
      s_rdata[63:32] = 32'hFFFF_FFFF;
      @(negedge clk);
      check("abort_no_rvalid", m_rvalid, 0);
      check("abort_gnt", m_gnt, 1);
      s_rvalid = '0;
      @(negedge clk);
      check("abort_no_rvalid_late", m_rvalid, 0);
      run_and_check(vecs[0].we, vecs[0].addr, vecs[0].wdata, vecs[0].wstrb, vecs[0].gdly,
                    vecs[0].rdly, vecs[0].sdata, vecs[0].sel, vecs[0].off,
                    vecs[0].lat, vecs[0].err, vecs[0].rdata);

      // Random traffic against the memory-map model.
      for (int t = 0; t < 40; t++) begin
         int          k, sel, g, r;
         logic [31:0] a, off, sd;
         k = $urandom_range(0, NSLV);
         a = (k < NSLV) ? (map_base[k] ^ ($urandom & ~map_mask[k])) : $urandom;
         decode(a, sel, off);
         g  = $urandom_range(0, MAX_DLY);
         r  = $urandom_range(0, MAX_DLY);
         sd = $urandom;
         run_and_check(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), g, r, sd, sel, off,
                       (sel < 0) ? 1 : 3 + g + r, sel < 0, (sel < 0) ? 32'h0 : sd);
         idle_quiet($urandom_range(0, 2), 4'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
